fetch_ctrl: RTL

Instruction fetch sequencer sitting between the core's instruction cache and the decode stage. Owns the program counter, drives the ICache address every cycle, captures the returned instruction word, and buffers `{pc, instr}` pairs in a small FIFO. Decode drains the FIFO with a valid/ready handshake. Branch/jump redirects from execute flush the FIFO and restart fetch at a new PC.

---
 rtl/fetch_ctrl.sv | 117 +++++++++++
 1 files changed

// File: rtl/fetch_ctrl.sv
// Instruction fetch sequencer: owns the PC, drives the ICache address, and
// buffers {pc, instr} pairs in a small FIFO drained by decode.
module fetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned DEPTH    = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        fetch_en,
    output logic [31:0] icache_addr,
    input  logic [31:0] icache_instr,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_pc,
    output logic [31:0] out_instr,
    output logic [15:0] fetched_cnt
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    logic [31:0]      r_pc;
    fetch_entry_t     r_mem [DEPTH];
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W-1:0] r_wr_ptr;
    logic [CNT_W-1:0] r_count;
    logic [15:0]      r_fetched_cnt;

    logic         w_valid;
    logic         w_full;
    logic         w_pop;
    logic         w_push;
    fetch_entry_t w_head;

    // Handshake qualifiers; a full FIFO still accepts a push when the head leaves.
    always_comb begin
        w_valid = (r_count != '0);
        w_full  = (r_count == FULL_CNT);
        w_pop   = w_valid & out_ready;
        w_push  = fetch_en & ~redirect_valid & (~w_full | w_pop);
        w_head  = r_mem[r_rd_ptr];
    end

    // Program counter: redirect wins, otherwise advance by one word per push.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pc <= RESET_PC;
        end else if (redirect_valid) begin
            r_pc <= {redirect_pc[31:2], 2'b00};
        end else if (w_push) begin
            r_pc <= r_pc + 32'd4;
        end
    end

    // FIFO pointers and occupancy; a redirect discards every entry.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else if (redirect_valid) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + CNT_W'(1);
            end else if (w_pop && !w_push) begin
                r_count <= r_count - CNT_W'(1);
            end
        end
    end

    // Entry storage, cleared on reset so the head never reads X.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_push) begin
            r_mem[r_wr_ptr] <= '{pc: r_pc, instr: icache_instr};
        end
    end

    // Count of pushes since reset, wrapping at 2^16.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_fetched_cnt <= '0;
        end else if (w_push) begin
            r_fetched_cnt <= r_fetched_cnt + 16'd1;
        end
    end

    // Outputs are straight reads of state.
    always_comb begin
        icache_addr = r_pc;
        out_valid   = w_valid;
        out_pc      = w_head.pc;
        out_instr   = w_head.instr;
        fetched_cnt = r_fetched_cnt;
    end

endmodule
